// File: rtl/imm_gen_pipe.sv
// RISC-V immediate decoder feeding a small FIFO. Each instruction is decoded
// when it is accepted; only the immediate and its format code are buffered.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_imm,
  output logic [2:0]               out_fmt,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_SH  = 3'd6;
  localparam logic [2:0] FMT_ILL = 3'd7;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  // Returns {fmt, imm}; bit 31 of the word is the sign for every extension.
  function automatic logic [XLEN+2:0] decode(input logic [31:0] inst);
    logic [2:0]      f;
    logic [XLEN-1:0] imm;
    f   = FMT_ILL;
    imm = '0;
    case (inst[6:0])
      7'b0000011, 7'b1100111, 7'b0001111: begin
        f   = FMT_I;
        imm = sext32({{20{inst[31]}}, inst[31:20]});
      end
      7'b0010011: begin
        if (inst[14:12] == 3'b001 || inst[14:12] == 3'b101) begin
          f   = FMT_SH;
          imm = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
        end else begin
          f   = FMT_I;
          imm = sext32({{20{inst[31]}}, inst[31:20]});
        end
      end
      7'b0100011: begin
        f   = FMT_S;
        imm = sext32({{20{inst[31]}}, inst[31:25], inst[11:7]});
      end
      7'b1100011: begin
        f   = FMT_B;
        imm = sext32({{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
      end
      7'b0110111, 7'b0010111: begin
        f   = FMT_U;
        imm = sext32({inst[31:12], 12'd0});
      end
      7'b1101111: begin
        f   = FMT_J;
        imm = sext32({{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
      end
      7'b0110011, 7'b1110011: begin
        f   = FMT_R;
        imm = '0;
      end
      default: begin
        f   = FMT_ILL;
        imm = '0;
      end
    endcase
    return {f, imm};
  endfunction

  logic [XLEN-1:0] imm_mem_q [DEPTH];
  logic [XLEN-1:0] imm_mem_d [DEPTH];
  logic [2:0]      fmt_mem_q [DEPTH];
  logic [2:0]      fmt_mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic            push_s, pop_s;
  logic [XLEN+2:0] dec_s;

  assign in_ready  = (level_q < DEPTH_L);
  assign out_valid = (level_q != '0);
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;
  assign dec_s     = decode(in_inst);
  assign level     = level_q;
  assign out_imm   = out_valid ? imm_mem_q[rd_ptr_q] : '0;
  assign out_fmt   = out_valid ? fmt_mem_q[rd_ptr_q] : 3'd0;

  // Next-state: flush wins over any push or pop in the same cycle.
  always_comb begin
    imm_mem_d = imm_mem_q;
    fmt_mem_d = fmt_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_s) begin
        imm_mem_d[wr_ptr_q] = dec_s[XLEN-1:0];
        fmt_mem_d[wr_ptr_q] = dec_s[XLEN+2:XLEN];
        wr_ptr_d            = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   level_d = level_q + (AW+1)'(1);
        2'b01:   level_d = level_q - (AW+1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        imm_mem_q[i] <= '0;
        fmt_mem_q[i] <= 3'd0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      imm_mem_q <= imm_mem_d;
      fmt_mem_q <= fmt_mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus
// and are checked against hand-computed immediates and FIFO behaviour.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic        in_ready32, out_valid32, in_ready64, out_valid64;
  logic [31:0] out_imm32;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt32, out_fmt64;
  logic [1:0]  level32, level64;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .DEPTH(2)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_inst(in_inst), .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_fmt(out_fmt32), .level(level32)
  );

  imm_gen_pipe #(.XLEN(64), .DEPTH(2)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_inst(in_inst), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_fmt(out_fmt64), .level(level64)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] e32, input logic [63:0] e64,
                          input logic [2:0] ef, input logic [1:0] elvl);
    chk({tag, " valid32"}, 64'(out_valid32), 64'd1);
    chk({tag, " valid64"}, 64'(out_valid64), 64'd1);
    chk({tag, " imm32"},   64'(out_imm32),   64'(e32));
    chk({tag, " imm64"},   out_imm64,        e64);
    chk({tag, " fmt32"},   64'(out_fmt32),   64'(ef));
    chk({tag, " fmt64"},   64'(out_fmt64),   64'(ef));
    chk({tag, " level32"}, 64'(level32),     64'(elvl));
    chk({tag, " level64"}, 64'(level64),     64'(elvl));
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, " valid32"},  64'(out_valid32), 64'd0);
    chk({tag, " valid64"},  64'(out_valid64), 64'd0);
    chk({tag, " imm32"},    64'(out_imm32),   64'd0);
    chk({tag, " imm64"},    out_imm64,        64'd0);
    chk({tag, " fmt32"},    64'(out_fmt32),   64'd0);
    chk({tag, " level32"},  64'(level32),     64'd0);
    chk({tag, " in_ready"}, 64'(in_ready32),  64'd1);
  endtask

  initial begin
    vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1}; // ADDI -1
    vecs[1]  = '{32'h123450B7, 32'h12345000, 64'h0000000012345000, 3'd4}; // LUI
    vecs[2]  = '{32'hFFFFF06F, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 3'd5}; // JAL -2
    vecs[3]  = '{32'h4030D093, 32'h00000003, 64'h0000000000000003, 3'd6}; // SRAI 3
    vecs[4]  = '{32'h8000006F, 32'hFFF00000, 64'hFFFFFFFFFFF00000, 3'd5}; // JAL min
    vecs[5]  = '{32'hFFF04083, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1}; // LBU -1
    vecs[6]  = '{32'h0000007F, 32'h00000000, 64'h0000000000000000, 3'd7}; // unknown
    vecs[7]  = '{32'hFE20AE23, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd2}; // SW -4
    vecs[8]  = '{32'h00000463, 32'h00000008, 64'h0000000000000008, 3'd3}; // BEQ +8
    vecs[9]  = '{32'hFE000FE3, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 3'd3}; // BEQ -2
    vecs[10] = '{32'h002081B3, 32'h00000000, 64'h0000000000000000, 3'd0}; // ADD
    vecs[11] = '{32'h00000073, 32'h00000000, 64'h0000000000000000, 3'd0}; // ECALL
    vecs[12] = '{32'h00000001, 32'h00000000, 64'h0000000000000000, 3'd7}; // compressed
    vecs[13] = '{32'hFFFFF097, 32'hFFFFF000, 64'hFFFFFFFFFFFFF000, 3'd4}; // AUIPC
    vecs[14] = '{32'h03F09093, 32'h0000001F, 64'h000000000000003F, 3'd6}; // SLLI 63
    vecs[15] = '{32'h7FF080E7, 32'h000007FF, 64'h00000000000007FF, 3'd1}; // JALR +2047

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_inst = 32'd0;
    #2;
    chk_empty("reset state");
    tick();
    reset = 1'b0;
    tick();

    // Table: push one word, check the head, then pop it.
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_inst = vecs[i].inst; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      chk_head($sformatf("vec%0d", i), vecs[i].imm32, vecs[i].imm64, vecs[i].fmt, 2'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk_empty($sformatf("vec%0d drained", i));
    end

    // Streaming with out_ready high: push and pop overlap, order kept.
    out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h123450B7;
    tick();
    chk_head("stream0", 32'h12345000, 64'h0000000012345000, 3'd4, 2'd1);
    in_inst = 32'hFFFFF06F;
    tick();
    chk_head("stream1", 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 3'd5, 2'd1);
    in_inst = 32'h4030D093;
    tick();
    chk_head("stream2", 32'h00000003, 64'h0000000000000003, 3'd6, 2'd1);
    in_valid = 1'b0;
    tick();
    chk_empty("stream end");
    out_ready = 1'b0;

    // Backpressure at DEPTH=2: A, B fill, C waits until space frees.
    in_valid = 1'b1; in_inst = 32'hFFF00093;
    tick();
    in_inst = 32'h123450B7;
    tick();
    chk("full in_ready32", 64'(in_ready32), 64'd0);
    chk("full in_ready64", 64'(in_ready64), 64'd0);
    chk_head("full A", 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 2'd2);
    in_inst = 32'h4030D093;
    tick();
    chk_head("held A", 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 2'd2);
    out_ready = 1'b1;
    tick();
    chk_head("pop A head B", 32'h12345000, 64'h0000000012345000, 3'd4, 2'd1);
    tick();
    in_valid = 1'b0;
    chk_head("pop B head C", 32'h00000003, 64'h0000000000000003, 3'd6, 2'd1);
    tick();
    chk_empty("bp drained");
    out_ready = 1'b0;

    // Flush while full with a word offered: everything gone.
    in_valid = 1'b1; in_inst = 32'hFFF00093;
    tick();
    in_inst = 32'h123450B7;
    tick();
    flush = 1'b1; in_inst = 32'hFFFFF06F;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk_empty("flush full");
    tick();
    chk_empty("flush full after");

    // Flush at level 1 with an acceptable word: that word is dropped too.
    in_valid = 1'b1; in_inst = 32'hFFF00093;
    tick();
    flush = 1'b1; in_inst = 32'h123450B7;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk_empty("flush lvl1");

    // Asynchronous reset with an illegal entry buffered.
    in_valid = 1'b1; in_inst = 32'h0000007F;
    tick();
    in_valid = 1'b0;
    chk_head("pre-reset", 32'h0, 64'h0, 3'd7, 2'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_empty("async reset");
    tick();
    reset = 1'b0;
    in_valid = 1'b1; in_inst = 32'h123450B7;
    tick();
    in_valid = 1'b0;
    chk_head("post-reset", 32'h12345000, 64'h0000000012345000, 3'd4, 2'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
